// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds AXI, UART and core domains in reset after any
// reset source, then releases them one at a time: AXI, then UART, then core.
// Sources are Rst_n, a software request and a watchdog. The most recent
// source is recorded in Rst_cause.
module rst_seq_ctrl #(
  parameter int unsigned HOLD_CYCLES = 16,  // 1..255
  parameter int unsigned STEP_CYCLES = 4    // 1..255
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Sw_rst_req,
  input  logic       Wdt_expire,
  output logic       Rst_n_axi,
  output logic       Rst_n_uart,
  output logic       Rst_n_core,
  output logic       Rst_done,
  output logic       Sw_rst_ack,
  output logic [1:0] Rst_cause
);

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    REL_AXI  = 2'd1,
    REL_UART = 2'd2,
    RUN      = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  // Terminal counts. The compare is done on the last count value, so a
  // parameter of 1 gives a one-edge phase.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] STEP_LAST = 8'(STEP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rst_n_axi_q, rst_n_axi_d;
  logic       rst_n_uart_q, rst_n_uart_d;
  logic       rst_n_core_q, rst_n_core_d;
  logic       rst_done_q, rst_done_d;
  logic       sw_rst_ack_q, sw_rst_ack_d;
  logic [1:0] rst_cause_q, rst_cause_d;

  // State register. Rst_n overrides every other input on the same edge.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q      <= HOLD;
      cnt_q        <= 8'd0;
      rst_n_axi_q  <= 1'b0;
      rst_n_uart_q <= 1'b0;
      rst_n_core_q <= 1'b0;
      rst_done_q   <= 1'b0;
      sw_rst_ack_q <= 1'b0;
      rst_cause_q  <= CAUSE_POR;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rst_n_axi_q  <= rst_n_axi_d;
      rst_n_uart_q <= rst_n_uart_d;
      rst_n_core_q <= rst_n_core_d;
      rst_done_q   <= rst_done_d;
      sw_rst_ack_q <= sw_rst_ack_d;
      rst_cause_q  <= rst_cause_d;
    end
  end

  // Next state and counter. A live request pins the FSM in HOLD with the
  // counter cleared, so a held request keeps restarting the hold window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (Wdt_expire || Sw_rst_req) begin
      state_d = HOLD;
      cnt_d   = 8'd0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = REL_AXI;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        REL_AXI: begin
          if (cnt_q == STEP_LAST) begin
            state_d = REL_UART;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        REL_UART: begin
          if (cnt_q == STEP_LAST) begin
            state_d = RUN;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        RUN: begin
          cnt_d = 8'd0;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state, so they change on the same
  // edge as the state and are glitch-free flops.
  always_comb begin
    rst_n_axi_d  = (state_d == REL_AXI) || (state_d == REL_UART) || (state_d == RUN);
    rst_n_uart_d = (state_d == REL_UART) || (state_d == RUN);
    rst_n_core_d = (state_d == RUN);
    rst_done_d   = (state_d == RUN);
    // The watchdog wins a tie with software, and then no ack is given.
    sw_rst_ack_d = Sw_rst_req && !Wdt_expire;
    rst_cause_d  = rst_cause_q;
    if (Wdt_expire)      rst_cause_d = CAUSE_WDT;
    else if (Sw_rst_req) rst_cause_d = CAUSE_SW;
  end

  assign Rst_n_axi  = rst_n_axi_q;
  assign Rst_n_uart = rst_n_uart_q;
  assign Rst_n_core = rst_n_core_q;
  assign Rst_done   = rst_done_q;
  assign Sw_rst_ack = sw_rst_ack_q;
  assign Rst_cause  = rst_cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Testbench for rst_seq_ctrl. Instance A uses the default parameters.
// Instance B uses HOLD_CYCLES=1 and STEP_CYCLES=1.
// Observed vector layout: {axi, uart, core, done, ack, cause[1:0]}.
module tb_rst_seq_ctrl;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic rst_a = 1'b0, sw_a = 1'b0, wdt_a = 1'b0;
  logic rst_b = 1'b0, sw_b = 1'b0, wdt_b = 1'b0;
  logic axi_a, uart_a, core_a, done_a, ack_a;
  logic axi_b, uart_b, core_b, done_b, ack_b;
  logic [1:0] cause_a, cause_b;

  rst_seq_ctrl u_dut_a (
    .Clk(Clk), .Rst_n(rst_a), .Sw_rst_req(sw_a), .Wdt_expire(wdt_a),
    .Rst_n_axi(axi_a), .Rst_n_uart(uart_a), .Rst_n_core(core_a),
    .Rst_done(done_a), .Sw_rst_ack(ack_a), .Rst_cause(cause_a)
  );

  rst_seq_ctrl #(.HOLD_CYCLES(1), .STEP_CYCLES(1)) u_dut_b (
    .Clk(Clk), .Rst_n(rst_b), .Sw_rst_req(sw_b), .Wdt_expire(wdt_b),
    .Rst_n_axi(axi_b), .Rst_n_uart(uart_b), .Rst_n_core(core_b),
    .Rst_done(done_b), .Sw_rst_ack(ack_b), .Rst_cause(cause_b)
  );

  wire [6:0] obs_a = {axi_a, uart_a, core_a, done_a, ack_a, cause_a};
  wire [6:0] obs_b = {axi_b, uart_b, core_b, done_b, ack_b, cause_b};

  typedef struct {
    string      nm;
    logic [6:0] exp;
  } sb_t;
  sb_t sb_q[$];

  int errors = 0;
  int checks = 0;

  // Drives one edge of inputs, queues the expectation, and then compares it
  // against the registered outputs just after the edge.
  task automatic step(input int d, input logic r, input logic s, input logic w,
                      input logic [6:0] e, input string nm);
    sb_t it;
    logic [6:0] got;
    if (d == 0) begin rst_a = r; sw_a = s; wdt_a = w; end
    else        begin rst_b = r; sw_b = s; wdt_b = w; end
    sb_q.push_back('{nm, e});
    @(posedge Clk);
    #1;
    it  = sb_q.pop_front();
    got = (d == 0) ? obs_a : obs_b;
    checks++;
    if (got !== it.exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %b want %b (axi,uart,core,done,ack,cause)",
               it.nm, d, $time, got, it.exp);
    end
  endtask

  // Idle edges after a reset source clears. The release times come from the
  // latency rule: axi after h edges, uart after h+s, core/done after h+2s.
  task automatic release_run(input int d, input int h, input int s,
                             input logic [1:0] cause, input int n, input string nm);
    logic [6:0] e;
    for (int k = 1; k <= n; k++) begin
      e = {1'(k >= h), 1'(k >= h + s), 1'(k >= h + 2 * s), 1'(k >= h + 2 * s),
           1'b0, cause};
      step(d, 1'b1, 1'b0, 1'b0, e, nm);
    end
  endtask

  typedef struct {
    logic       r, s, w;
    logic [6:0] exp;
    logic [1:0] cause;
    string      nm;
  } vec_t;
  vec_t tbl[5];

  localparam int H = 16;
  localparam int S = 4;
  localparam int FULL = H + 2 * S + 1;

  initial begin
    // Each event is applied from RUN and followed by a full re-release.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 7'b0000_1_01, 2'b01, "sw_in_run"};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 7'b0000_0_10, 2'b10, "wdt_in_run"};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 7'b0000_1_01, 2'b01, "sw_again"};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 7'b0000_0_10, 2'b10, "sw_and_wdt"};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 7'b0000_0_00, 2'b00, "rst_overrides"};

    // Power-on reset: Rst_n low for 3 edges, then the default release.
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, 1'b0, 7'b0000_0_00, "por_hold");
    release_run(0, H, S, 2'b00, FULL, "por_release");

    for (int i = 0; i < 5; i++) begin
      step(0, tbl[i].r, tbl[i].s, tbl[i].w, tbl[i].exp, tbl[i].nm);
      release_run(0, H, S, tbl[i].cause, FULL, {tbl[i].nm, "_release"});
    end

    // Watchdog while in REL_UART drops the released domains, then restarts.
    step(0, 1'b1, 1'b1, 1'b0, 7'b0000_1_01, "pre_sw");
    release_run(0, H, S, 2'b01, H + S, "to_rel_uart");
    step(0, 1'b1, 1'b0, 1'b1, 7'b0000_0_10, "wdt_in_rel_uart");
    release_run(0, H, S, 2'b10, FULL, "wdt_uart_release");

    // Software request held for 5 edges: an ack on each edge, and all held.
    for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b1, 1'b0, 7'b0000_1_01, "sw_held");
    release_run(0, H, S, 2'b01, FULL, "sw_held_release");

    // Rst_n pulled low in REL_AXI takes effect on that edge.
    release_run(0, H, S, 2'b01, 0, "noop");
    step(0, 1'b1, 1'b0, 1'b1, 7'b0000_0_10, "pre_wdt");
    release_run(0, H, S, 2'b10, H + 1, "to_rel_axi");
    step(0, 1'b0, 1'b0, 1'b0, 7'b0000_0_00, "rst_mid_seq");
    release_run(0, H, S, 2'b00, FULL, "rst_mid_release");

    // Minimum-parameter instance: release on edges 1/2/3, then Rst_n in RUN.
    for (int i = 0; i < 2; i++) step(1, 1'b0, 1'b0, 1'b0, 7'b0000_0_00, "b_por");
    release_run(1, 1, 1, 2'b00, 4, "b_release");
    step(1, 1'b1, 1'b1, 1'b0, 7'b0000_1_01, "b_sw");
    release_run(1, 1, 1, 2'b01, 4, "b_sw_release");
    step(1, 1'b0, 1'b0, 1'b0, 7'b0000_0_00, "b_rst_in_run");
    release_run(1, 1, 1, 2'b00, 4, "b_rst_release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 16, meaning all-domains-held cycles after a reset source clears; legal range 1..255.
REQ-002 The block SHALL have parameter STEP_CYCLES, default 4, meaning cycles between successive domain releases; legal range 1..255.
REQ-003 Port Clk  input  1  system clock; all logic on rising edge.
REQ-004 Port Rst_n  input  1  reset: one clock; reset is synchronous and active-low.
REQ-005 Port Sw_rst_req  input  1  software reset request, level, sampled each edge.
REQ-006 Port Wdt_expire  input  1  watchdog reset request, level, sampled each edge.
REQ-007 Port Rst_n_axi  output  1  active-low reset to AXI domain, released first.
REQ-008 Port Rst_n_uart  output  1  active-low reset to UART domain, released second.
REQ-009 Port Rst_n_core  output  1  active-low reset to core domain, released last.
REQ-010 Port Rst_done  output  1  high while all domains released.
REQ-011 Port Sw_rst_ack  output  1  one-cycle pulse accepting a software request.
REQ-012 Port Rst_cause  output  2  last reset source: 00 power-on/Rst_n, 01 software, 10 watchdog; 11 unused.

Function
REQ-013 The block SHALL implement states HOLD, REL_AXI, REL_UART, RUN, with an 8-bit cycle counter Cnt.
REQ-014 All outputs SHALL be registered; Rst_n_axi=1 in REL_AXI/REL_UART/RUN, Rst_n_uart=1 in REL_UART/RUN, Rst_n_core=1 and Rst_done=1 only in RUN, else 0.
REQ-015 HOLD: Cnt increments each edge; at Cnt==HOLD_CYCLES-1 the next state SHALL be REL_AXI with Cnt=0.
REQ-016 REL_AXI: Cnt increments; at Cnt==STEP_CYCLES-1 next state SHALL be REL_UART, Cnt=0.
REQ-017 REL_UART: Cnt increments; at Cnt==STEP_CYCLES-1 next state SHALL be RUN, Cnt=0.
REQ-018 RUN: Cnt SHALL hold 0; state remains until a reset source.
REQ-019 Wdt_expire=1 in any state SHALL force HOLD, Cnt=0, Rst_cause=10 on the next edge.
REQ-020 Sw_rst_req=1 with Wdt_expire=0 in any state SHALL force HOLD, Cnt=0, Rst_cause=01, and Sw_rst_ack=1 for that one cycle.
REQ-021 Sw_rst_req and Wdt_expire both high SHALL be treated as watchdog; Sw_rst_ack SHALL stay 0.
REQ-022 A request held high for N edges SHALL keep the block in HOLD with Cnt=0 and SHALL pulse Sw_rst_ack on every such edge (software deasserts after ack).
REQ-023 A request arriving mid-sequence SHALL restart the full sequence from HOLD; no partially released domain stays released.
REQ-024 Release latency from the first edge with no active source: Rst_n_axi high after HOLD_CYCLES edges, Rst_n_uart after HOLD_CYCLES+STEP_CYCLES, Rst_n_core/Rst_done after HOLD_CYCLES+2*STEP_CYCLES.
REQ-025 Rst_cause SHALL be sticky, changing only on a new reset source.

Reset
REQ-026 Rst_n=0 at an edge SHALL override all other inputs: state=HOLD, Cnt=0, Rst_n_axi=Rst_n_uart=Rst_n_core=0, Rst_done=0, Sw_rst_ack=0, Rst_cause=00.
REQ-027 Rst_n=0 asserted mid-sequence or in RUN SHALL take effect on that same edge with the values of REQ-026.

Verification
REQ-028 Defaults, Rst_n low 3 edges then high -> Rst_n_axi rises after edge 16, Rst_n_uart after 20, Rst_n_core and Rst_done after 24; Rst_cause=00.
REQ-029 In RUN, Sw_rst_req high 1 cycle -> next edge all domain resets 0, Sw_rst_ack=1 one cycle, Rst_cause=01, re-release at +16/+20/+24.
REQ-030 In REL_UART, Wdt_expire high 1 cycle -> Rst_n_axi and Rst_n_uart drop next edge, Rst_cause=10, full 16/20/24 sequence restarts.
REQ-031 Sw_rst_req and Wdt_expire high on same edge in RUN -> Rst_cause=10, Sw_rst_ack stays 0.
REQ-032 Sw_rst_req held high 5 edges -> Sw_rst_ack high 5 cycles, outputs 0 throughout, release 16 edges after request drops.
REQ-033 HOLD_CYCLES=1, STEP_CYCLES=1, Rst_n in RUN pulled low 1 edge -> all outputs 0, Rst_cause=00, Rst_n_axi/uart/core rise after edges 1/2/3.
